fat32_bpb_parser: RTL

- Consumes the 512-byte byte stream of FAT32 sector 0 (BPB) as read from the SD card.
- Extracts the volume geometry fields in little-endian order and validates the 0x55AA signature.
- Registers the geometry for the root-directory sector calculation stage directly downstream (reserved sectors, FAT length, FAT count).
- Sits between the SD block-read engine and the FAT32 file-write address logic.

---
 rtl/fat32_pkg.sv | 39 +++
 rtl/bpb_le_field_capture.sv | 56 +++++
 rtl/fat32_bpb_parser.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fat32_pkg.sv
// ---------------------------------------------------------------------------
// fat32_pkg
// Shared constants for the FAT32 boot-sector (BPB) parser:
//   - byte offsets of the BPB fields inside sector 0
//   - boot signature values
//   - parser state encoding
//   - err_code values
// No ports (package).
// ---------------------------------------------------------------------------
package fat32_pkg;

  // Byte offsets inside sector 0
  localparam int OFF_BYTES_PER_SEC = 11;  // 2 bytes
  localparam int OFF_SPC           = 13;  // 1 byte
  localparam int OFF_RSVD          = 14;  // 2 bytes
  localparam int OFF_NUM_FAT       = 16;  // 1 byte
  localparam int OFF_FATSZ32       = 36;  // 4 bytes
  localparam int OFF_ROOT_CLUS     = 44;  // 4 bytes
  localparam int OFF_SIG0          = 510;
  localparam int OFF_SIG1          = 511;

  // Boot signature
  localparam logic [7:0] SIG0_VAL = 8'h55;
  localparam logic [7:0] SIG1_VAL = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_SIG = 2'b01;
  localparam logic [1:0] ERR_LENGTH  = 2'b10;
  localparam logic [1:0] ERR_SANITY  = 2'b11;

endpackage

// File: rtl/bpb_le_field_capture.sv
// ---------------------------------------------------------------------------
// bpb_le_field_capture
// Loads one little-endian multi-byte field from the sector byte stream into a
// shadow register. Byte at stream index OFFSET lands in field[7:0], the byte
// at OFFSET+1 in field[15:8], and so on.
// Parameters: OFFSET (first byte index), NBYTES (field width in bytes),
//             CNT_W (width of the byte index).
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   en           a byte is being accepted this cycle
//   cnt          index of the byte being accepted
//   data         the byte being accepted
//   field        captured shadow field
// ---------------------------------------------------------------------------
module bpb_le_field_capture #(
  parameter int OFFSET = 0,
  parameter int NBYTES = 1,
  parameter int CNT_W  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CNT_W-1:0]      cnt,
  input  logic [7:0]            data,
  output logic [8*NBYTES-1:0]   field
);

  logic [8*NBYTES-1:0] field_q;
  logic [8*NBYTES-1:0] field_d;
  logic [NBYTES-1:0]   byte_hit;

  // One index decoder per byte lane of the field
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign byte_hit[gi] = en && (cnt == CNT_W'(OFFSET + gi));
  end

  always_comb begin
    field_d = field_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_hit[i]) begin
        field_d[8*i +: 8] = data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_q <= '0;
    end else begin
      field_q <= field_d;
    end
  end

  assign field = field_q;

endmodule

// File: rtl/fat32_bpb_parser.sv
// ---------------------------------------------------------------------------
// fat32_bpb_parser
// Parses the 512-byte FAT32 sector 0 stream, checks the 55 AA signature and
// commits the volume geometry for the downstream root-directory address
// calculation. Geometry outputs only change on a successful parse.
// Optional: define BPB_SANITY_CHECK_EN to additionally reject images with a
// wrong BytesPerSector, NumFATs outside 1..2, a non power-of-two
// SectorsPerCluster or a zero FATSz32 (err_code 11).
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   start               pulse; arms the parser for one frame (IDLE/DONE/ERR)
//   rx_valid/data/last  byte stream from the SD read engine
//   rx_ready            high while bytes are being accepted
//   busy, done, error   status (done/error are levels until next start)
//   err_code            01 bad signature, 10 length mismatch, 11 sanity
//   ReservedSectors, theLengthOfFAT, NumberOfFAT, SectorsPerCluster,
//   RootCluster         committed geometry
// ---------------------------------------------------------------------------
module fat32_bpb_parser
  import fat32_pkg::*;
#(
  parameter int SECTOR_BYTES = 512,
  parameter int CNT_W        = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  output logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] ReservedSectors,
  output logic [31:0] theLengthOfFAT,
  output logic [8:0]  NumberOfFAT,
  output logic [7:0]  SectorsPerCluster,
  output logic [31:0] RootCluster
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               sig0_ok_q, sig0_ok_d;
  logic               sig1_ok_q, sig1_ok_d;
  logic [15:0]        rsvd_q, rsvd_d;
  logic [31:0]        fatsz_q, fatsz_d;
  logic [8:0]         num_fat_q, num_fat_d;
  logic [7:0]         spc_q, spc_d;
  logic [31:0]        root_q, root_d;

  logic               accept;
  logic [7:0]         sh_spc;
  logic [15:0]        sh_rsvd;
  logic [7:0]         sh_num_fat;
  logic [31:0]        sh_fatsz;
  logic [31:0]        sh_root;

  assign accept = (state_q == ST_RECV) && rx_valid;

  bpb_le_field_capture #(.OFFSET(OFF_SPC), .NBYTES(1), .CNT_W(CNT_W)) u_cap_spc (
    .clk(clk), .rst_n(rst_n), .en(accept), .cnt(cnt_q), .data(rx_data), .field(sh_spc));
  bpb_le_field_capture #(.OFFSET(OFF_RSVD), .NBYTES(2), .CNT_W(CNT_W)) u_cap_rsvd (
    .clk(clk), .rst_n(rst_n), .en(accept), .cnt(cnt_q), .data(rx_data), .field(sh_rsvd));
  bpb_le_field_capture #(.OFFSET(OFF_NUM_FAT), .NBYTES(1), .CNT_W(CNT_W)) u_cap_nfat (
    .clk(clk), .rst_n(rst_n), .en(accept), .cnt(cnt_q), .data(rx_data), .field(sh_num_fat));
  bpb_le_field_capture #(.OFFSET(OFF_FATSZ32), .NBYTES(4), .CNT_W(CNT_W)) u_cap_fatsz (
    .clk(clk), .rst_n(rst_n), .en(accept), .cnt(cnt_q), .data(rx_data), .field(sh_fatsz));
  bpb_le_field_capture #(.OFFSET(OFF_ROOT_CLUS), .NBYTES(4), .CNT_W(CNT_W)) u_cap_root (
    .clk(clk), .rst_n(rst_n), .en(accept), .cnt(cnt_q), .data(rx_data), .field(sh_root));

`ifdef BPB_SANITY_CHECK_EN
  logic [15:0] sh_bps;
  logic        sanity_ok;

  bpb_le_field_capture #(.OFFSET(OFF_BYTES_PER_SEC), .NBYTES(2), .CNT_W(CNT_W)) u_cap_bps (
    .clk(clk), .rst_n(rst_n), .en(accept), .cnt(cnt_q), .data(rx_data), .field(sh_bps));

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign sanity_ok = (sh_bps == 16'(SECTOR_BYTES))
                  && ((sh_num_fat == 8'd1) || (sh_num_fat == 8'd2))
                  && (sh_spc != 8'd0)
                  && ((sh_spc & (sh_spc - 8'd1)) == 8'd0)
                  && (sh_fatsz != 32'd0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    sig0_ok_d  = sig0_ok_q;
    sig1_ok_d  = sig1_ok_q;
    rsvd_d     = rsvd_q;
    fatsz_d    = fatsz_q;
    num_fat_d  = num_fat_q;
    spc_d      = spc_q;
    root_d     = root_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_RECV;
          cnt_d      = '0;
          err_code_d = ERR_NONE;
          sig0_ok_d  = 1'b0;
          sig1_ok_d  = 1'b0;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q == CNT_W'(OFF_SIG0)) && (rx_data == SIG0_VAL)) sig0_ok_d = 1'b1;
          if ((cnt_q == CNT_W'(OFF_SIG1)) && (rx_data == SIG1_VAL)) sig1_ok_d = 1'b1;
          // Final byte index wins over rx_last: a correctly sized frame always checks
          if (cnt_q == CNT_W'(SECTOR_BYTES - 1)) begin
            state_d = ST_CHECK;
          end else if (rx_last) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LENGTH;
          end
        end
      end
      ST_CHECK: begin
        if (!(sig0_ok_q && sig1_ok_q)) begin
          state_d    = ST_ERR;
          err_code_d = ERR_BAD_SIG;
`ifdef BPB_SANITY_CHECK_EN
        end else if (!sanity_ok) begin
          state_d    = ST_ERR;
          err_code_d = ERR_SANITY;
`endif
        end else begin
          state_d   = ST_DONE;
          rsvd_d    = sh_rsvd;
          fatsz_d   = sh_fatsz;
          num_fat_d = {1'b0, sh_num_fat};
          spc_d     = sh_spc;
          root_d    = sh_root;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_code_q <= ERR_NONE;
      sig0_ok_q  <= 1'b0;
      sig1_ok_q  <= 1'b0;
      rsvd_q     <= '0;
      fatsz_q    <= '0;
      num_fat_q  <= '0;
      spc_q      <= '0;
      root_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      sig0_ok_q  <= sig0_ok_d;
      sig1_ok_q  <= sig1_ok_d;
      rsvd_q     <= rsvd_d;
      fatsz_q    <= fatsz_d;
      num_fat_q  <= num_fat_d;
      spc_q      <= spc_d;
      root_q     <= root_d;
    end
  end

  assign rx_ready          = (state_q == ST_RECV);
  assign busy              = (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign done              = (state_q == ST_DONE);
  assign error             = (state_q == ST_ERR);
  assign err_code          = err_code_q;
  assign ReservedSectors   = rsvd_q;
  assign theLengthOfFAT    = fatsz_q;
  assign NumberOfFAT       = num_fat_q;
  assign SectorsPerCluster = spc_q;
  assign RootCluster       = root_q;

endmodule
